// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and ID-side resolution signals of the branch predictor.
// The master side drives PCs and resolutions; the slave side returns predictions and counters.
interface branch_predictor_if;
  localparam int unsigned PC_W = 16;

  logic [PC_W-1:0] pc_IF;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;

  logic            update_en;
  logic [PC_W-1:0] update_pc;
  logic            update_taken;
  logic [PC_W-1:0] update_target;
  logic            update_pred_taken;
  logic [PC_W-1:0] update_pred_pc;

  logic            mispredict;
  logic [PC_W-1:0] correct_pc;
  logic [PC_W-1:0] branch_count;
  logic [PC_W-1:0] mispredict_count;

  modport master (
    output pc_IF, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_pc,
    input  pred_taken, pred_pc, mispredict, correct_pc, branch_count, mispredict_count
  );

  modport slave (
    input  pc_IF, update_en, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_pc,
    output pred_taken, pred_pc, mispredict, correct_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// ID-stage update, mispredict detection and resolved/mispredict statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int unsigned PC_W  = 16;
  localparam int unsigned TAG_W = PC_W - IDX_BITS;
  localparam int unsigned CTR_W = 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_W'(1)};

  entry_t              btb_q [ENTRIES];
  logic [PC_W-1:0]     branch_count_q;
  logic [PC_W-1:0]     mispredict_count_q;

  logic [IDX_BITS-1:0] idx;
  logic                hit;
  logic [IDX_BITS-1:0] uidx;
  entry_t              ucur;
  logic                uhit;
  entry_t              unxt;
  logic                unused_pred_taken;

  // The carried-down prediction bit is redundant with update_pred_pc for mispredict detection.
  assign unused_pred_taken = bp.update_pred_taken;

  // Fetch lookup reads the pre-edge table contents.
  assign idx           = bp.pc_IF[IDX_BITS-1:0];
  assign hit           = btb_q[idx].valid && (btb_q[idx].tag == bp.pc_IF[PC_W-1:IDX_BITS]);
  assign bp.pred_taken = hit && btb_q[idx].ctr[CTR_W-1];
  assign bp.pred_pc    = bp.pred_taken ? btb_q[idx].target : bp.pc_IF + PC_W'(1);

  assign bp.correct_pc = bp.update_taken ? bp.update_target : bp.update_pc + PC_W'(1);
  assign bp.mispredict = bp.update_en && (bp.update_pred_pc != bp.correct_pc);

  assign uidx = bp.update_pc[IDX_BITS-1:0];
  assign ucur = btb_q[uidx];
  assign uhit = ucur.valid && (ucur.tag == bp.update_pc[PC_W-1:IDX_BITS]);

  // Next value of the entry addressed by the resolved instruction.
  always_comb begin
    unxt = ucur;
    if (uhit) begin
      if (bp.update_taken) begin
        unxt.ctr    = (ucur.ctr == '1) ? ucur.ctr : ucur.ctr + CTR_W'(1);
        unxt.target = bp.update_target;
      end else begin
        unxt.ctr    = (ucur.ctr == '0) ? ucur.ctr : ucur.ctr - CTR_W'(1);
      end
    end else if (bp.update_taken) begin
      unxt.valid  = 1'b1;
      unxt.tag    = bp.update_pc[PC_W-1:IDX_BITS];
      unxt.target = bp.update_target;
      unxt.ctr    = CTR_W'(2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) btb_q[i] <= ENTRY_RST;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bp.update_en) begin
        btb_q[uidx]    <= unxt;
        branch_count_q <= branch_count_q + PC_W'(1);
      end
      if (bp.mispredict) mispredict_count_q <= mispredict_count_q + PC_W'(1);
    end
  end

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against an array-based
// model of the predictor table and its statistics counters.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if bif ();
  branch_predictor #(.ENTRIES(16), .IDX_BITS(4)) dut (.clk(clk), .reset(reset), .bp(bif.slave));

  int total = 0;
  int bad   = 0;

  int m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_bc, m_mc;

  task automatic chk(string name, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit m_taken(int pc);
    int i;
    i = pc % 16;
    return (m_valid[i] != 0) && (m_tag[i] == pc / 16) && (m_ctr[i] >= 2);
  endfunction

  function automatic int m_pred_pc(int pc);
    return m_taken(pc) ? m_tgt[pc % 16] : (pc + 1) % 65536;
  endfunction

  function automatic int m_correct();
    return bif.update_taken ? int'(bif.update_target) : (int'(bif.update_pc) + 1) % 65536;
  endfunction

  function automatic bit m_misp();
    return bif.update_en && (int'(bif.update_pred_pc) != m_correct());
  endfunction

  function automatic void m_update();
    int pc, i;
    bit hit;
    if (!bif.update_en) return;
    pc  = int'(bif.update_pc);
    i   = pc % 16;
    hit = (m_valid[i] != 0) && (m_tag[i] == pc / 16);
    if (m_misp()) m_mc = (m_mc + 1) % 65536;
    m_bc = (m_bc + 1) % 65536;
    if (hit) begin
      if (bif.update_taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = int'(bif.update_target);
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (bif.update_taken) begin
      m_valid[i] = 1; m_tag[i] = pc / 16; m_tgt[i] = int'(bif.update_target); m_ctr[i] = 2;
    end
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".pred_taken"}, 16'(bif.pred_taken), 16'(m_taken(int'(bif.pc_IF))));
    chk({tag, ".pred_pc"},    bif.pred_pc,          16'(m_pred_pc(int'(bif.pc_IF))));
    chk({tag, ".mispredict"}, 16'(bif.mispredict), 16'(m_misp()));
    chk({tag, ".correct_pc"}, bif.correct_pc,       16'(m_correct()));
    chk({tag, ".branch_cnt"}, bif.branch_count,     16'(m_bc));
    chk({tag, ".mispr_cnt"},  bif.mispredict_count, 16'(m_mc));
  endtask

  // Check combinational outputs against the model, then advance one edge.
  task automatic tick(string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (!reset) m_update();
    #1;
  endtask

  task automatic set_upd(logic [15:0] pc, logic tk, logic [15:0] tgt, logic ppt, logic [15:0] ppc);
    bif.update_en = 1'b1; bif.update_pc = pc; bif.update_taken = tk;
    bif.update_target = tgt; bif.update_pred_taken = ppt; bif.update_pred_pc = ppc;
  endtask

  task automatic idle();
    bif.update_en = 1'b0;
  endtask

  function automatic logic [15:0] rnd_pc();
    int t;
    t = $urandom_range(0, 2);
    return ((t == 2) ? 16'hFFF0 : 16'(t << 4)) | 16'($urandom_range(0, 3));
  endfunction

  initial begin
    m_reset();
    reset = 1'b1;
    bif.pc_IF = 16'h0010;
    set_upd(16'h0050, 1'b1, 16'h0077, 1'b0, 16'h0051);
    #1;
    // During reset: cleared outputs, and the coincident update is dropped.
    chk("rst.pred_taken", 16'(bif.pred_taken), 16'h0000);
    chk("rst.pred_pc", bif.pred_pc, 16'h0011);
    tick("rst");
    reset = 1'b0;
    idle();
    bif.pc_IF = 16'h0050;
    tick("rst_discard");
    bif.pc_IF = 16'h0010;
    #1;
    chk("cold.pred_taken", 16'(bif.pred_taken), 16'h0000);
    chk("cold.pred_pc", bif.pred_pc, 16'h0011);
    chk("cold.branch_cnt", bif.branch_count, 16'h0000);
    tick("cold");

    // Allocate, with a same-cycle lookup of the same PC.
    bif.pc_IF = 16'h0023;
    set_upd(16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0024);
    #1;
    chk("alloc.mispredict", 16'(bif.mispredict), 16'h0001);
    chk("alloc.correct_pc", bif.correct_pc, 16'h0040);
    chk("alloc.same_cycle_pt", 16'(bif.pred_taken), 16'h0000);
    tick("alloc");
    idle();
    #1;
    chk("hit.pred_taken", 16'(bif.pred_taken), 16'h0001);
    chk("hit.pred_pc", bif.pred_pc, 16'h0040);
    chk("hit.mispr_cnt", bif.mispredict_count, 16'h0001);
    tick("hit");

    // Saturation sequence on 0x0023.
    for (int k = 0; k < 3; k++) begin
      set_upd(16'h0023, 1'b1, 16'h0040, 1'b1, 16'h0040);
      tick("sat_t");
    end
    set_upd(16'h0023, 1'b0, 16'h0000, 1'b1, 16'h0040);
    tick("sat_nt1");
    idle(); #1;
    chk("sat_nt1.pred_taken", 16'(bif.pred_taken), 16'h0001);
    set_upd(16'h0023, 1'b0, 16'h0000, 1'b1, 16'h0040);
    tick("sat_nt2");
    idle(); #1;
    chk("sat_nt2.pred_taken", 16'(bif.pred_taken), 16'h0000);
    chk("sat_nt2.pred_pc", bif.pred_pc, 16'h0024);
    set_upd(16'h0023, 1'b0, 16'h0000, 1'b0, 16'h0024);
    tick("sat_nt3");
    set_upd(16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0024);
    tick("sat_t_after_00");
    idle(); #1;
    chk("sat_01.pred_taken", 16'(bif.pred_taken), 16'h0000);
    tick("sat_01");

    // Alias: same index, different tag.
    set_upd(16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0024);
    tick("alias_train");
    bif.pc_IF = 16'h0013;
    idle(); #1;
    chk("alias.pred_taken", 16'(bif.pred_taken), 16'h0000);
    chk("alias.pred_pc", bif.pred_pc, 16'h0014);
    set_upd(16'h0013, 1'b0, 16'h0000, 1'b0, 16'h0014);
    tick("alias_nt");
    idle();
    bif.pc_IF = 16'h0023;
    #1;
    chk("alias_keep.pred_taken", 16'(bif.pred_taken), 16'h0001);
    chk("alias_keep.pred_pc", bif.pred_pc, 16'h0040);
    tick("alias_keep");

    // PC wrap.
    bif.pc_IF = 16'hFFFF;
    set_upd(16'hFFFF, 1'b0, 16'h1234, 1'b0, 16'h0000);
    #1;
    chk("wrap.pred_pc", bif.pred_pc, 16'h0000);
    chk("wrap.mispredict", 16'(bif.mispredict), 16'h0000);
    chk("wrap.correct_pc", bif.correct_pc, 16'h0000);
    tick("wrap");

    // Randomized traffic over a few aliasing tags.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] upc;
      bif.pc_IF = rnd_pc();
      upc = rnd_pc();
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) != 0)
          set_upd(upc, 1'($urandom), 16'($urandom_range(0, 3) << 4), m_taken(int'(upc)),
                  16'(m_pred_pc(int'(upc))));
        else
          set_upd(upc, 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      end else begin
        idle();
      end
      tick("rand");
    end

    // Asynchronous reset between edges after five taken updates.
    for (int k = 0; k < 5; k++) begin
      set_upd(16'h0023, 1'b1, 16'h0040, 1'b1, 16'h0040);
      tick("pre_rst");
    end
    idle();
    bif.pc_IF = 16'h0023;
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("async.branch_cnt", bif.branch_count, 16'h0000);
    chk("async.mispr_cnt", bif.mispredict_count, 16'h0000);
    chk("async.pred_taken", 16'(bif.pred_taken), 16'h0000);
    chk("async.pred_pc", bif.pred_pc, 16'h0024);
    set_upd(16'h0023, 1'b1, 16'h0040, 1'b0, 16'h0024);
    tick("async_hold");
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bif.pc_IF = rnd_pc();
      set_upd(rnd_pc(), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
      tick("post_rst");
    end
    idle();
    tick("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL use the following parameters: ENTRIES, 16, number of direct-mapped BTB entries; IDX_BITS, 4, log2(ENTRIES).
REQ-002 The block SHALL expose these ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pc_IF  input  16  current fetch PC, word-addressed.
- pred_taken  output  1  fetch-stage taken prediction.
- pred_pc  output  16  next fetch PC.
- update_en  input  1  a resolved branch or jump is in ID this cycle.
- update_pc  input  16  PC of the resolved instruction.
- update_taken  input  1  actual outcome; bcond result for branches, 1 for jumps.
- update_target  input  16  actual target.
- update_pred_taken  input  1  prediction carried down from IF.
- update_pred_pc  input  16  pred_pc carried down from IF.
- mispredict  output  1  resolved outcome differs from the prediction.
- correct_pc  output  16  PC to refetch on mispredict.
- branch_count  output  16  resolved-instruction counter.
- mispredict_count  output  16  mispredict counter.
REQ-003 Only one clock domain SHALL exist: clk, with reset asynchronous and active-high.

Function
REQ-004 Each entry SHALL hold: valid (1 bit), tag (16-IDX_BITS bits), target (16 bits) and a 2-bit counter.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-005 Lookup SHALL be combinational:
- idx = pc_IF[3:0].
- hit = valid[idx] && tag[idx] == pc_IF[15:4].
REQ-006 pred_taken SHALL equal hit && counter[idx][1].
REQ-007 pred_pc SHALL equal target[idx] when pred_taken is 1, else pc_IF+1 modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-008 Update SHALL be applied at the rising clk edge when update_en is 1, with uidx = update_pc[3:0].
REQ-009 On an update hit (valid and tag match):
- Counter increments if update_taken, saturating at 11.
- Counter decrements if not taken, saturating at 00.
- If update_taken, target is overwritten with update_target.
REQ-010 On an update miss with update_taken=1, the entry SHALL be allocated/replaced: valid=1, tag=update_pc[15:4], target=update_target, counter=10.
REQ-011 On an update miss with update_taken=0, table state SHALL be unchanged.
REQ-012 A same-cycle lookup and update to the same index SHALL return the pre-edge contents; the new state is visible from the next cycle.
REQ-013 When update_en=0, the table and counters SHALL hold.
REQ-014 mispredict SHALL be combinational: update_en && (update_pred_pc != correct_pc).
REQ-015 correct_pc SHALL equal update_target when update_taken=1, else update_pc+1 modulo 2^16.
REQ-016 branch_count SHALL increment by 1 on every edge with update_en=1, wrapping FFFF->0000.
REQ-017 mispredict_count SHALL increment on every edge with mispredict=1, with the same wrap rule.
REQ-018 The block SHALL not stall. The upstream pipeline drops update_en for stalled or flushed ID slots; the block performs no internal qualification.

Reset
REQ-019 While reset=1, without waiting for clk, the block SHALL hold:
- all valid=0, all counters=01, tags and targets=0;
- branch_count=0, mispredict_count=0.
REQ-020 During reset, outputs SHALL follow from the cleared state: pred_taken=0, pred_pc=pc_IF+1.
REQ-021 An update coincident with a reset assertion SHALL be discarded.
REQ-022 Deasserting reset mid-sequence SHALL resume from the cleared state on the next edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Cold lookup: after reset, pc_IF=16'h0010 -> pred_taken=0, pred_pc=16'h0011.
- Allocate then hit: update_en, update_pc=16'h0023, taken=1, target=16'h0040, pred_pc=16'h0024; then pc_IF=16'h0023 -> mispredict=1 in the update cycle, correct_pc=16'h0040; next cycle pred_taken=1, pred_pc=16'h0040, mispredict_count=1.
- Saturation: same branch taken 3 more times -> counter 11. Then 2 not-taken -> counter 01, pred_taken=0. Then 1 further not-taken -> 00. Then 1 taken -> 01 (still not predicted).
- Alias/tag miss: entry at 16'h0023 valid; pc_IF=16'h0013 -> pred_taken=0. A not-taken update of 16'h0013 -> entry for 16'h0023 unchanged.
- Wrap: pc_IF=16'hFFFF, no hit -> pred_pc=16'h0000. A not-taken update at 16'hFFFF with update_pred_pc=16'h0000 -> mispredict=0.
- Async reset mid-run: assert reset between edges after 5 updates -> counters read 0 immediately and the prior hit PC predicts not-taken.
